// File: rtl/mem_access_unit.sv
// Data-memory access controller: turns MR/MW strobes into a req/ack memory
// transaction, stalls the core while it is in flight and returns load data.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_W          = 4
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        MR,
  input  logic        MW,
  input  logic [15:0] Addr,
  input  logic [15:0] Wr_Data,
  input  logic [15:0] Mem_RData,
  input  logic        Mem_Ack,
  output logic [15:0] Mem_Addr,
  output logic [15:0] Mem_WData,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic [15:0] W_MEM_IN,
  output logic        Load_Valid,
  output logic        Stall,
  output logic        Bus_Error
);

  localparam int unsigned      DATA_W   = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                we_q, we_d;
  logic                req_q, req_d;
  logic                load_valid_q, load_valid_d;
  logic                bus_error_q, bus_error_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      we_q         <= 1'b0;
      req_q        <= 1'b0;
      load_valid_q <= 1'b0;
      bus_error_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      we_q         <= we_d;
      req_q        <= req_d;
      load_valid_q <= load_valid_d;
      bus_error_q  <= bus_error_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state and register-update logic
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    we_d         = we_q;
    req_d        = req_q;
    cnt_d        = cnt_q;
    load_valid_d = 1'b0;
    bus_error_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (MR ^ MW) begin
          addr_d  = Addr;
          wdata_d = Wr_Data;
          we_d    = MW;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else if (MR & MW) begin
          // Conflicting strobes: retire the instruction with an error, no access
          bus_error_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_WAIT: begin
        if (Mem_Ack) begin
          req_d        = 1'b0;
          load_valid_d = ~we_q;
          if (!we_q) begin
            rdata_d = Mem_RData;
          end
          state_d = ST_DONE;
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (cnt_q == CNT_LAST) begin
            req_d        = 1'b0;
            bus_error_d  = 1'b1;
            load_valid_d = ~we_q;
            if (!we_q) begin
              rdata_d = '1;
            end
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stall drops in DONE so the register bank captures W_MEM_IN on that edge
  assign Stall = ((state_q == ST_IDLE) & (MR ^ MW)) | (state_q == ST_WAIT);

  assign Mem_Addr   = addr_q;
  assign Mem_WData  = wdata_q;
  assign Mem_Req    = req_q;
  assign Mem_We     = we_q;
  assign W_MEM_IN   = rdata_q;
  assign Load_Valid = load_valid_q;
  assign Bus_Error  = bus_error_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access controller sitting directly downstream of super_register_bank.
- Takes the Working register (address), Data_B (store data) and the decoder's MR/MW strobes, and runs a request/acknowledge transaction with the external data memory.
- Stalls the core until the transaction completes, then returns load data on W_MEM_IN, which the register bank writes into W (Sel_C = 34, MR = 1).

Parameters:
- TIMEOUT_CYCLES, default 15: maximum WAIT cycles without Mem_Ack before the access is aborted.
- CNT_W, default 4: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- nreset  input  1  asynchronous, active-low reset.
- MR  input  1  memory-read request from the decoder; held for the whole instruction.
- MW  input  1  memory-write request from the decoder; held for the whole instruction.
- Addr  input  16  access address, driven by Working_register.
- Wr_Data  input  16  store data, driven by Data_B.
- Mem_RData  input  16  read data from memory; valid when Mem_Ack = 1.
- Mem_Ack  input  1  memory completion strobe.
- Mem_Addr  output  16  registered address to memory.
- Mem_WData  output  16  registered store data to memory.
- Mem_Req  output  1  registered request, held until ack or timeout.
- Mem_We  output  1  1 = write, 0 = read; meaningful only while Mem_Req = 1.
- W_MEM_IN  output  16  registered load result to the register bank.
- Load_Valid  output  1  one-cycle pulse in DONE when the completed access was a read.
- Stall  output  1  combinational; holds the core.
- Bus_Error  output  1  one-cycle error pulse.

Behaviour:
- Reset (nreset = 0, asynchronous):
  - State goes to IDLE.
  - Mem_Addr, Mem_WData, W_MEM_IN and the timeout counter clear to 0.
  - Mem_Req, Mem_We, Load_Valid and Bus_Error clear to 0.
  - Stall follows its equation, so it is 0 in IDLE while MR and MW are low.
- States: IDLE, WAIT, DONE.
- IDLE:
  - Exactly one of MR/MW high at the edge: latch Addr into Mem_Addr, Wr_Data into Mem_WData, and MW into Mem_We. Set Mem_Req = 1, clear the counter, go to WAIT.
  - MR and MW both high: no access is issued. Bus_Error pulses for 1 cycle and the state goes to DONE, so the instruction retires. Load_Valid = 0 and W_MEM_IN is unchanged.
  - Neither high: stay in IDLE.
- WAIT:
  - Mem_Req, Mem_Addr, Mem_WData and Mem_We stay stable.
  - Mem_Ack = 1 at the edge: drop Mem_Req. If the access is a read, capture Mem_RData into W_MEM_IN. Go to DONE.
  - No ack: increment the counter. If the counter equals TIMEOUT_CYCLES - 1 at the edge, abort:
    - Mem_Req = 0, Bus_Error pulses for 1 cycle.
    - If the access is a read, W_MEM_IN = 16'hFFFF.
    - Go to DONE.
  - Ack and timeout on the same edge: ack wins, no error.
- DONE:
  - Lasts 1 cycle; Load_Valid = 1 if the access was a read. Always returns to IDLE.
  - MR/MW are ignored in this cycle. They belong to the retiring instruction, so a repeat access is never issued.
- Stall equation: Stall = (IDLE & (MR ^ MW)) | WAIT. Stall is 0 in DONE, so the core advances and the register bank loads W on that edge.
- Latency:
  - Minimum for an access with ack in the first WAIT cycle: 2 stall cycles (IDLE + WAIT), then DONE.
  - Load data is visible on W_MEM_IN from the start of DONE.
- Mem_Ack outside WAIT is ignored, with no side effect.
- Back-to-back accesses: the earliest a new request can be accepted is the IDLE cycle following DONE.
- W_MEM_IN holds its last value between loads; writes never modify it.
- Reset mid-transaction: Mem_Req drops immediately (asynchronous). No DONE, Load_Valid or Bus_Error is produced, and a late Mem_Ack after reset is ignored.
- All arithmetic is unsigned, no sign extension; the counter saturates and never wraps.

Test Plan:
- Reset, then read: MR = 1, Addr = 16'h0040; Mem_Ack = 1 with Mem_RData = 16'hBEEF on the 1st WAIT cycle -> Mem_Req high for exactly 1 cycle with Mem_We = 0 and Mem_Addr = 16'h0040; Stall high for 2 cycles; DONE with W_MEM_IN = 16'hBEEF and Load_Valid = 1 for 1 cycle.
- Write with a 3-cycle ack delay: MW = 1, Addr = 16'h0123, Wr_Data = 16'h5A5A -> Mem_We = 1 and Mem_WData = 16'h5A5A stable for 3 cycles; Stall high for 4 cycles; Load_Valid = 0; W_MEM_IN unchanged.
- Timeout: read with Mem_Ack held low and TIMEOUT_CYCLES = 15 -> Mem_Req drops after 15 WAIT cycles; Bus_Error pulses for 1 cycle; W_MEM_IN = 16'hFFFF; Load_Valid = 1; returns to IDLE.
- Illegal request: MR = MW = 1 -> Mem_Req never asserts; Bus_Error pulses for 1 cycle; state passes through DONE to IDLE; Stall = 0 throughout.
- Reset mid-access: nreset low during WAIT, then Mem_Ack pulsed after release -> Mem_Req = 0 immediately; state is IDLE; no Load_Valid or Bus_Error pulse; W_MEM_IN = 0.
- Back-to-back: read 16'h0010 (ack with Mem_RData = 16'h1111), then a write to 16'h0011 presented in the next instruction -> the second Mem_Req asserts on the edge after the IDLE cycle that follows DONE; both transactions complete with the correct data.
